// File: rtl/brick_pkg.sv
// Shared constants, loader state encoding and brick addressing for the brick map controller.
package brick_pkg;

  localparam int NUM_COLS     = 12;
  localparam int NUM_ROWS     = 7;
  localparam int NUM_BRICKS   = NUM_COLS * NUM_ROWS;
  localparam int LEVEL_STRIDE = 128;
  localparam int NUM_LEVELS   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } load_state_e;

  typedef struct packed {
    logic       valid;
    logic [6:0] idx;
  } brick_idx_t;

  // Out-of-range coordinates come back invalid with index 0, so a caller can index safely.
  function automatic brick_idx_t brick_index(input logic [2:0] row, input logic [3:0] col);
    brick_idx_t r;
    r.valid = (col < 4'(NUM_COLS)) && (row < 3'(NUM_ROWS));
    r.idx   = r.valid ? (7'(row) * 7'(NUM_COLS) + 7'(col)) : 7'd0;
    return r;
  endfunction

  function automatic logic [7:0] level_base(input logic lvl);
    return lvl ? 8'(LEVEL_STRIDE) : 8'd0;
  endfunction

endpackage

// File: rtl/brick_loader.sv
// Level-load sequencer: walks the level ROM and streams returning bits to the map owner.
// ST_IDLE: waiting for start | ST_FETCH: issuing addresses 0..83 | ST_DONE: capture bit 83
module brick_loader
  import brick_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       level_i,
  input  logic       rom_data_i,
  output logic [7:0] rom_addr_o,
  output logic       busy_o,
  output logic       wr_en_o,
  output logic [6:0] wr_idx_o,
  output logic       wr_data_o,
  output logic       done_o
);

  load_state_e state_q;
  logic [6:0]  cnt_q;
  logic        level_q;
  logic [7:0]  rom_addr_q;
  logic        busy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_FETCH;
            level_q    <= level_i;
            cnt_q      <= '0;
            rom_addr_q <= level_base(level_i);
            busy_q     <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (cnt_q == 7'(NUM_BRICKS - 1)) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q      <= cnt_q + 7'd1;
            rom_addr_q <= level_base(level_q) + {1'b0, cnt_q + 7'd1};
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ROM data lags the address by one cycle, so each write targets the previous counter value.
  assign wr_en_o    = ((state_q == ST_FETCH) && (cnt_q != 7'd0)) || (state_q == ST_DONE);
  assign wr_idx_o   = (state_q == ST_DONE) ? 7'(NUM_BRICKS - 1) : (cnt_q - 7'd1);
  assign wr_data_o  = rom_data_i;
  assign done_o     = (state_q == ST_DONE);
  assign rom_addr_o = rom_addr_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/brick_map_controller.sv
// Live brick map for one Breakout level: ROM load, renderer lookup, hit test-and-clear,
// brick count and level-clear flag.
module brick_map_controller
  import brick_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_req_i,
  input  logic       level_i,
  output logic       load_busy_o,
  output logic [7:0] rom_addr_o,
  input  logic       rom_data_i,
  input  logic [3:0] vid_col_i,
  input  logic [2:0] vid_row_i,
  output logic       vid_brick_o,
  input  logic       hit_req_i,
  input  logic [3:0] hit_col_i,
  input  logic [2:0] hit_row_i,
  output logic       hit_ack_o,
  output logic       hit_was_brick_o,
  output logic [6:0] bricks_left_o,
  output logic       level_clear_o
);

  logic [NUM_BRICKS-1:0] map_q;
  logic [6:0]            bricks_q;
  logic                  loaded_q;
  logic                  vid_brick_q;
  logic                  hit_ack_q;
  logic                  hit_was_q;

  logic       busy;
  logic       load_start;
  logic       hit_go;
  logic       wr_en;
  logic [6:0] wr_idx;
  logic       wr_data;
  logic       ld_done;
  brick_idx_t vid_idx;
  brick_idx_t hit_idx;

  brick_loader u_loader (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (load_start),
    .level_i    (level_i),
    .rom_data_i (rom_data_i),
    .rom_addr_o (rom_addr_o),
    .busy_o     (busy),
    .wr_en_o    (wr_en),
    .wr_idx_o   (wr_idx),
    .wr_data_o  (wr_data),
    .done_o     (ld_done)
  );

  assign vid_idx    = brick_index(vid_row_i, vid_col_i);
  assign hit_idx    = brick_index(hit_row_i, hit_col_i);
  assign load_start = load_req_i & ~busy;
  // Load wins a tie; the skipped cycle after an ack lets the requester drop its request.
  assign hit_go     = hit_req_i & ~busy & ~load_req_i & ~hit_ack_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      map_q       <= '0;
      bricks_q    <= '0;
      loaded_q    <= 1'b0;
      vid_brick_q <= 1'b0;
      hit_ack_q   <= 1'b0;
      hit_was_q   <= 1'b0;
    end else begin
      hit_ack_q   <= 1'b0;
      hit_was_q   <= 1'b0;
      vid_brick_q <= vid_idx.valid & map_q[vid_idx.idx];
      if (load_start) begin
        map_q    <= '0;
        bricks_q <= '0;
        loaded_q <= 1'b0;
      end else if (wr_en) begin
        map_q[wr_idx] <= wr_data;
        bricks_q      <= bricks_q + {6'd0, wr_data};
      end else if (hit_go) begin
        hit_ack_q <= 1'b1;
        if (hit_idx.valid && map_q[hit_idx.idx]) begin
          hit_was_q            <= 1'b1;
          map_q[hit_idx.idx]   <= 1'b0;
          bricks_q             <= bricks_q - 7'd1;
        end
      end
      if (ld_done) begin
        loaded_q <= 1'b1;
      end
    end
  end

  assign load_busy_o     = busy;
  assign vid_brick_o     = vid_brick_q;
  assign hit_ack_o       = hit_ack_q;
  assign hit_was_brick_o = hit_was_q;
  assign bricks_left_o   = bricks_q;
  assign level_clear_o   = loaded_q & ~busy & (bricks_q == 7'd0);

endmodule
